// File: rtl/sistema_pio_pkg.sv
// ---------------------------------------------------------------------------
// sistema_pio_pkg
// Shared constants for the edge-capture PIO: Avalon-MM register word
// addresses, the capture-mode encodings used by the EDGE_MODE parameter,
// and the saturation ceiling of the event counter.
// ---------------------------------------------------------------------------
package sistema_pio_pkg;

    // Register word addresses
    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK  = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP  = 2'd2;
    localparam logic [1:0] ADDR_EVTCOUNT = 2'd3;

    // Capture-mode encodings for EDGE_MODE
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Event counter width and saturation value
    localparam int         EVTCOUNT_W   = 16;
    localparam logic [15:0] EVTCOUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/sistema_sync_edge.sv
// ---------------------------------------------------------------------------
// sistema_sync_edge
// Per-bit multi-flop synchroniser followed by a one-clock delay stage and
// combinational edge detection.
//
// Ports:
//   clk       - system clock
//   reset     - asynchronous active-high reset
//   in_port   - asynchronous external inputs (WIDTH bits)
//   sync_q    - last synchroniser stage (clean, clock-domain value)
//   edge_evt  - per-bit edge event for the selected EDGE_MODE
// ---------------------------------------------------------------------------
module sistema_sync_edge #(
    parameter int WIDTH       = 13,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_q,
    output logic [WIDTH-1:0] edge_evt
);
    import sistema_pio_pkg::*;

    logic [WIDTH-1:0] chain [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    // Synchroniser chain plus the delayed copy used for edge comparison.
    // Everything resets to 0, so an input held high through reset shows up
    // as a rising transition once it reaches sync_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            chain[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev_q <= chain[SYNC_STAGES-1];
        end
    end

    assign sync_q = chain[SYNC_STAGES-1];

    // Edge detection on the synchronised value against its previous cycle.
    always_comb begin
        edge_evt = '0;
        if (EDGE_MODE == EDGE_FALLING) begin
            edge_evt = ~sync_q & prev_q;
        end else if (EDGE_MODE == EDGE_ANY) begin
            edge_evt = sync_q ^ prev_q;
        end else begin
            edge_evt = sync_q & ~prev_q;
        end
    end

endmodule

// File: rtl/sistema_edge_pio.sv
// ---------------------------------------------------------------------------
// sistema_edge_pio
// Avalon-MM slave edge-capture parallel input port with interrupt.
// Registers: DATA (synchronised inputs), IRQMASK (RW), EDGECAP (W1C),
// EVTCOUNT (saturating count of cycles with any edge; any write clears).
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous active-high reset
//   address    - register word address
//   chipselect - slave select, qualifies write
//   write      - write strobe
//   writedata  - write data
//   in_port    - asynchronous external inputs (WIDTH bits)
//   readdata   - registered read data, one-cycle latency, zero-extended
//   irq        - registered level interrupt, |(EDGECAP & IRQMASK)
// ---------------------------------------------------------------------------
module sistema_edge_pio #(
    parameter int WIDTH       = 13,
    parameter int EDGE_MODE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    import sistema_pio_pkg::*;

    logic [WIDTH-1:0]      sync_q;
    logic [WIDTH-1:0]      edge_evt;
    logic [WIDTH-1:0]      irqmask;
    logic [WIDTH-1:0]      edgecap;
    logic [EVTCOUNT_W-1:0] evtcount;
    logic [WIDTH-1:0]      cap_clear;
    logic [31:0]           read_mux;
    logic                  wr_en;
    logic                  any_evt;
    logic                  unused_wdata;

    sistema_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MODE)
    ) u_sync_edge (
        .clk      (clk),
        .reset    (reset),
        .in_port  (in_port),
        .sync_q   (sync_q),
        .edge_evt (edge_evt)
    );

    assign wr_en   = chipselect & write;
    assign any_evt = |edge_evt;

    // Upper writedata bits are deliberately discarded by every register.
    assign unused_wdata = ^writedata;

    // Bits being cleared by a write-1-to-clear access this cycle.
    always_comb begin
        cap_clear = '0;
        if (wr_en && address == ADDR_EDGECAP) begin
            cap_clear = writedata[WIDTH-1:0];
        end
    end

    // Register file. The event OR is applied after the clear so a capture
    // in the same cycle as its W1C survives. irq looks at the registered
    // EDGECAP/IRQMASK, so it follows them by one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask  <= '0;
            edgecap  <= '0;
            evtcount <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr_en && address == ADDR_IRQMASK) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            edgecap <= (edgecap & ~cap_clear) | edge_evt;
            if (wr_en && address == ADDR_EVTCOUNT) begin
                evtcount <= any_evt ? EVTCOUNT_W'(1) : '0;
            end else if (any_evt && evtcount != EVTCOUNT_MAX) begin
                evtcount <= evtcount + 1'b1;
            end
            irq <= |(edgecap & irqmask);
        end
    end

    // Read mux, independent of chipselect.
    always_comb begin
        read_mux = '0;
        case (address)
            ADDR_DATA:     read_mux[WIDTH-1:0]      = sync_q;
            ADDR_IRQMASK:  read_mux[WIDTH-1:0]      = irqmask;
            ADDR_EDGECAP:  read_mux[WIDTH-1:0]      = edgecap;
            ADDR_EVTCOUNT: read_mux[EVTCOUNT_W-1:0] = evtcount;
            default:       read_mux                 = '0;
        endcase
    end

    // Registered read data gives the one-cycle read latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= read_mux;
        end
    end

endmodule

// File: tb/tb_sistema_edge_pio.sv
// ---------------------------------------------------------------------------
// tb_sistema_edge_pio
// Drives two instances of the PIO from a shared bus: one rising-edge with a
// 2-stage synchroniser, one any-edge with a 3-stage synchroniser. A
// reference model predicts readdata/irq every clock into per-instance
// queues; a monitor pops and compares on the falling edge.
// ---------------------------------------------------------------------------
module tb_sistema_edge_pio;

    localparam int W = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    address;
    logic          chipselect;
    logic          write;
    logic [31:0]   writedata;
    logic [W-1:0]  in_port;
    logic [31:0]   rd0, rd1;
    logic          irq0, irq1;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] rd;
        logic        irq;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    // Reference model state: input history and per-instance registers.
    logic [W-1:0]  hist [5];
    logic [W-1:0]  m_mask [2];
    logic [W-1:0]  m_cap  [2];
    logic [15:0]   m_cnt  [2];

    sistema_edge_pio #(.WIDTH(W), .EDGE_MODE(0), .SYNC_STAGES(2)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (rd0),
        .irq        (irq0)
    );

    sistema_edge_pio #(.WIDTH(W), .EDGE_MODE(2), .SYNC_STAGES(3)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write      (write),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (rd1),
        .irq        (irq1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] a, input logic cs, input logic wr,
                                 input logic [31:0] wd, input logic [W-1:0] inp);
        @(negedge clk);
        address    = a;
        chipselect = cs;
        write      = wr;
        writedata  = wd;
        in_port    = inp;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(2'd0, 1'b0, 1'b0, 32'h0, in_port);
        end
    endtask

    task automatic readReg(input logic [1:0] a, input logic [31:0] e0, input logic [31:0] e1);
        applyStimulus(a, 1'b0, 1'b0, 32'h0, in_port);
        @(negedge clk);
        checkOutput("dut0_read", rd0, e0);
        checkOutput("dut2_read", rd1, e1);
    endtask

    // Reference model: the synchronised value seen by an instance with
    // depth N is the input sampled N clocks earlier; the previous value is
    // one clock older still. Register rules follow the register map.
    initial begin
        exp_t         e;
        logic [W-1:0] s, p, evt;
        int           depth, mode;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int k = 0; k < 5; k++) hist[k] = '0;
                for (int i = 0; i < 2; i++) begin
                    m_mask[i] = '0;
                    m_cap[i]  = '0;
                    m_cnt[i]  = '0;
                end
                q0.delete();
                q1.delete();
            end else begin
                for (int i = 0; i < 2; i++) begin
                    depth = (i == 0) ? 2 : 3;
                    mode  = (i == 0) ? 0 : 2;
                    s = hist[depth-1];
                    p = hist[depth];
                    if (mode == 0)      evt = s & ~p;
                    else if (mode == 1) evt = ~s & p;
                    else                evt = s ^ p;
                    case (address)
                        2'd0:    e.rd = {19'b0, s};
                        2'd1:    e.rd = {19'b0, m_mask[i]};
                        2'd2:    e.rd = {19'b0, m_cap[i]};
                        default: e.rd = {16'b0, m_cnt[i]};
                    endcase
                    e.irq = |(m_cap[i] & m_mask[i]);
                    if (chipselect && write && address == 2'd1) m_mask[i] = writedata[W-1:0];
                    if (chipselect && write && address == 2'd2) m_cap[i] = m_cap[i] & ~writedata[W-1:0];
                    m_cap[i] = m_cap[i] | evt;
                    if (chipselect && write && address == 2'd3)
                        m_cnt[i] = (evt != 0) ? 16'd1 : 16'd0;
                    else if (evt != 0 && m_cnt[i] < 16'hFFFF)
                        m_cnt[i] = m_cnt[i] + 16'd1;
                    if (i == 0) q0.push_back(e);
                    else        q1.push_back(e);
                end
                for (int k = 4; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = in_port;
            end
        end
    end

    // Monitor: every clock after reset, the DUT presents readdata/irq.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (q0.size() > 0) begin
                    e = q0.pop_front();
                    checkOutput("sb_dut0_readdata", rd0, e.rd);
                    checkOutput("sb_dut0_irq", {31'b0, irq0}, {31'b0, e.irq});
                end
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    checkOutput("sb_dut2_readdata", rd1, e.rd);
                    checkOutput("sb_dut2_irq", {31'b0, irq1}, {31'b0, e.irq});
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write      = 1'b0;
        writedata  = 32'h0;
        in_port    = '0;

        // Reset state
        #22;
        checkOutput("reset_rd0", rd0, 32'h0);
        checkOutput("reset_irq0", {31'b0, irq0}, 32'h0);
        checkOutput("reset_rd2", rd1, 32'h0);
        @(negedge clk);
        #2 reset = 1'b0;
        for (int a = 0; a < 4; a++) readReg(a[1:0], 32'h0, 32'h0);
        checkOutput("post_reset_irq", {31'b0, irq0}, 32'h0);

        // Rising edges on bits 0 and 2
        applyStimulus(2'd0, 1'b0, 1'b0, 32'h0, 13'h0005);
        idle(5);
        readReg(2'd2, 32'h5, 32'h5);
        readReg(2'd0, 32'h5, 32'h5);
        readReg(2'd3, 32'h1, 32'h1);

        // Mask bit 2 -> irq; clear bit 2 -> irq drops
        applyStimulus(2'd1, 1'b1, 1'b1, 32'h4, in_port);
        idle(1);
        @(negedge clk);
        checkOutput("irq_after_mask", {31'b0, irq0}, 32'h1);
        applyStimulus(2'd2, 1'b1, 1'b1, 32'h4, in_port);
        readReg(2'd2, 32'h1, 32'h1);
        checkOutput("irq_after_w1c", {31'b0, irq0}, 32'h0);

        // W1C of bit 0 lands on the same cycle as its rising-edge capture
        applyStimulus(2'd0, 1'b0, 1'b0, 32'h0, 13'h0004);
        idle(5);
        applyStimulus(2'd0, 1'b0, 1'b0, 32'h0, 13'h0005);
        idle(1);
        applyStimulus(2'd2, 1'b1, 1'b1, 32'h1, in_port);
        idle(3);
        @(negedge clk);
        applyStimulus(2'd2, 1'b0, 1'b0, 32'h0, in_port);
        @(negedge clk);
        checkOutput("set_wins_over_w1c", rd0 & 32'h1, 32'h1);

        // Randomised bus traffic and input activity
        for (int n = 0; n < 400; n++) begin
            applyStimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), $urandom,
                          ($urandom_range(0, 3) == 0) ? W'($urandom) : in_port);
        end

        // Saturation: toggle bit 1 every clock
        applyStimulus(2'd0, 1'b0, 1'b0, 32'h0, '0);
        idle(6);
        applyStimulus(2'd3, 1'b1, 1'b1, 32'h0, in_port);
        for (int n = 0; n < 70000; n++) begin
            applyStimulus(2'd3, 1'b0, 1'b0, 32'h0, in_port ^ 13'h0002);
        end
        idle(6);
        readReg(2'd3, 32'd35000, 32'h0000FFFF);
        applyStimulus(2'd3, 1'b1, 1'b1, 32'hFFFFFFFF, in_port);
        readReg(2'd3, 32'h0, 32'h0);

        // Reset mid-operation with all captures set and irq asserted
        applyStimulus(2'd1, 1'b1, 1'b1, 32'h1FFF, '0);
        idle(6);
        applyStimulus(2'd0, 1'b0, 1'b0, 32'h0, 13'h1FFF);
        idle(7);
        readReg(2'd2, 32'h1FFF, 32'h1FFF);
        checkOutput("irq_before_reset0", {31'b0, irq0}, 32'h1);
        checkOutput("irq_before_reset2", {31'b0, irq1}, 32'h1);
        applyStimulus(2'd2, 1'b0, 1'b0, 32'h0, '0);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_rd0", rd0, 32'h0);
        checkOutput("async_reset_irq0", {31'b0, irq0}, 32'h0);
        checkOutput("async_reset_rd2", rd1, 32'h0);
        checkOutput("async_reset_irq2", {31'b0, irq1}, 32'h0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        idle(8);
        for (int a = 0; a < 4; a++) readReg(a[1:0], 32'h0, 32'h0);
        checkOutput("no_irq_after_release0", {31'b0, irq0}, 32'h0);
        checkOutput("no_irq_after_release2", {31'b0, irq1}, 32'h0);

        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sistema_edge_pio.md
SISTEMA_EDGE_PIO -- requirements
Module: sistema_edge_pio

Interface
REQ-001 Parameter WIDTH, default 13, input port width; legal range 1..32.
REQ-002 Parameter EDGE_MODE, default 0, capture mode: 0 rising, 1 falling, 2 any edge.
REQ-003 Parameter SYNC_STAGES, default 2, input synchroniser depth; legal range 2..4.
REQ-004 Port clk, input, 1, single clock for all logic.
REQ-005 Port reset, input, 1, asynchronous, active-high reset.
REQ-006 Port address, input, 2, Avalon-MM word address.
REQ-007 Port chipselect, input, 1, slave select.
REQ-008 Port write, input, 1, write strobe; qualified by chipselect.
REQ-009 Port writedata, input, 32, write data.
REQ-010 Port in_port, input, WIDTH, asynchronous external inputs.
REQ-011 Port readdata, output, 32, registered read data.
REQ-012 Port irq, output, 1, level interrupt request.

Function
REQ-013 in_port SHALL pass through a SYNC_STAGES-deep flop chain per bit; sync_q is the last stage, prev_q is sync_q delayed one clock.
REQ-014 Edge event per bit SHALL be: mode 0 sync_q & ~prev_q; mode 1 ~sync_q & prev_q; mode 2 sync_q ^ prev_q.
REQ-015 Register map: 0 DATA (RO, sync_q); 1 IRQMASK (RW, WIDTH bits); 2 EDGECAP (RO, write-1-to-clear); 3 EVTCOUNT (RO, 16 bits, any write clears).
REQ-016 readdata SHALL update every clock from address, independent of chipselect: selected register zero-extended to 32 bits; one-cycle read latency.
REQ-017 Writes to address 0 SHALL be ignored; writedata bits above WIDTH (above 16 for EVTCOUNT) SHALL be ignored.
REQ-018 EDGECAP bit SHALL set on its edge event and hold until cleared by writing 1 to that bit at address 2.
REQ-019 Simultaneous edge event and W1C on the same bit: set SHALL win (bit remains 1).
REQ-020 EVTCOUNT SHALL increment by 1 in each cycle where at least one edge event occurs (regardless of mask), saturating at 0xFFFF.
REQ-021 Write to address 3 concurrent with an event cycle: EVTCOUNT SHALL become 1; otherwise 0.
REQ-022 irq SHALL be registered: irq <= |(EDGECAP & IRQMASK), asserting the clock after the capture bit sets or the mask bit is written.
REQ-023 Latency in_port change -> EDGECAP visible on readdata SHALL be SYNC_STAGES+2 clocks.

Reset
REQ-024 On reset: all synchroniser flops, prev_q, IRQMASK, EDGECAP, EVTCOUNT, readdata and irq SHALL be 0, asynchronously.
REQ-025 After reset release, no edge event SHALL be reported until sync_q differs from prev_q; an input held high through reset SHALL produce one rising event after release (mode 0/2).
REQ-026 Reset asserted mid-operation SHALL discard pending captures and count with no spurious irq on release.

Structure
REQ-027 Package sistema_pio_pkg SHALL hold register address constants (ADDR_DATA..ADDR_EVTCOUNT) and the EDGE_MODE encodings.
REQ-028 Sub-module sistema_sync_edge (synchroniser + edge detect, parameterised by WIDTH, SYNC_STAGES, EDGE_MODE) SHALL be instantiated once; register file and read mux stay in the top.

Verification
REQ-029 Reset, WIDTH=13: read all four addresses -> 0x0 each; irq=0.
REQ-030 Mode 0: drive in_port 0x0000 -> 0x0005, wait 5 clocks, read addr 2 -> 0x5, addr 0 -> 0x5, addr 3 -> 0x1.
REQ-031 IRQMASK=0x4 with EDGECAP=0x5 -> irq=1 next clock; write 0x4 to addr 2 -> EDGECAP 0x1, irq=0 one clock later.
REQ-032 Same-cycle W1C of bit 0 and rising edge on bit 0 -> EDGECAP bit 0 stays 1.
REQ-033 Toggle bit 1 in mode 2 for 70000 event cycles -> EVTCOUNT=0xFFFF; write addr 3 -> 0x0.
REQ-034 Assert reset with EDGECAP=0x1FFF, irq=1 -> irq and all registers 0 immediately; no irq after release with inputs static low.
